// File: rtl/issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : issue_sched
// Brief    : Issue scheduler for ALU, multiplier and memory ports with a
//            multiplier occupancy counter. Define ISSUE_SCHED_RR_EN for
//            round-robin arbitration; the default is fixed lowest-index priority.
// Revision : 1.0 - initial release
// ============================================================================
module issue_sched #(
    parameter int RS_SZ    = 5,
    parameter int MULT_LAT = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [RS_SZ-1:0]           req_valid,
    input  logic [RS_SZ-1:0][1:0]      req_fu,
    input  logic                       mem_ready,
    input  logic                       flush,
    output logic                       alu_gnt,
    output logic                       mult_gnt,
    output logic                       mem_gnt,
    output logic [$clog2(RS_SZ)-1:0]   alu_idx,
    output logic [$clog2(RS_SZ)-1:0]   mult_idx,
    output logic [$clog2(RS_SZ)-1:0]   mem_idx,
    output logic                       mult_busy,
    output logic                       mult_done,
    output logic [$clog2(RS_SZ)-1:0]   mult_done_idx
);

    localparam int                 c_IDX_W    = $clog2(RS_SZ);
    localparam int                 c_CNT_W    = 4;
    localparam logic [1:0]         c_FU_ALU   = 2'd0;
    localparam logic [1:0]         c_FU_MULT  = 2'd1;
    localparam logic [1:0]         c_FU_LOAD  = 2'd2;
    localparam logic [1:0]         c_FU_STORE = 2'd3;

    // Returns {found, index}: first requester at or above ptr, else the
    // lowest-index requester (wrap-around search).
    function automatic logic [c_IDX_W:0] f_pick(
        input logic [RS_SZ-1:0]   req,
        input logic [c_IDX_W-1:0] ptr
    );
        logic               hi_found;
        logic               any_found;
        logic [c_IDX_W-1:0] hi_idx;
        logic [c_IDX_W-1:0] any_idx;
        hi_found  = 1'b0;
        any_found = 1'b0;
        hi_idx    = '0;
        any_idx   = '0;
        for (int i = RS_SZ - 1; i >= 0; i--) begin
            if (req[c_IDX_W'(i)]) begin
                any_found = 1'b1;
                any_idx   = c_IDX_W'(i);
                if (c_IDX_W'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = c_IDX_W'(i);
                end
            end
        end
        return hi_found ? {1'b1, hi_idx} : {any_found, any_idx};
    endfunction

    logic [RS_SZ-1:0]   w_alu_req;
    logic [RS_SZ-1:0]   w_mult_req;
    logic [RS_SZ-1:0]   w_mem_req;
    logic [c_IDX_W-1:0] w_alu_ptr;
    logic [c_IDX_W-1:0] w_mult_ptr;
    logic [c_IDX_W-1:0] w_mem_ptr;
    logic [c_IDX_W:0]   w_alu_pick;
    logic [c_IDX_W:0]   w_mult_pick;
    logic [c_IDX_W:0]   w_mem_pick;

    logic [c_CNT_W-1:0] r_mult_cnt;
    logic [c_IDX_W-1:0] r_mult_tag;
    logic               r_mult_done;
    logic [c_IDX_W-1:0] r_mult_done_idx;

    // Each entry carries exactly one FU class, so the three request sets are
    // disjoint and no entry can be granted twice in a cycle.
    for (genvar g = 0; g < RS_SZ; g++) begin : g_req
        assign w_alu_req[g]  = req_valid[g] && (req_fu[g] == c_FU_ALU);
        assign w_mult_req[g] = req_valid[g] && (req_fu[g] == c_FU_MULT);
        assign w_mem_req[g]  = req_valid[g] &&
                               ((req_fu[g] == c_FU_LOAD) || (req_fu[g] == c_FU_STORE));
    end

`ifdef ISSUE_SCHED_RR_EN
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(RS_SZ - 1);

    logic [c_IDX_W-1:0] r_alu_ptr;
    logic [c_IDX_W-1:0] r_mult_ptr;
    logic [c_IDX_W-1:0] r_mem_ptr;

    function automatic logic [c_IDX_W-1:0] f_next(input logic [c_IDX_W-1:0] idx);
        return (idx == c_LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_alu_ptr  <= '0;
            r_mult_ptr <= '0;
            r_mem_ptr  <= '0;
        end else begin
            if (alu_gnt)  r_alu_ptr  <= f_next(alu_idx);
            if (mult_gnt) r_mult_ptr <= f_next(mult_idx);
            if (mem_gnt)  r_mem_ptr  <= f_next(mem_idx);
        end
    end

    assign w_alu_ptr  = r_alu_ptr;
    assign w_mult_ptr = r_mult_ptr;
    assign w_mem_ptr  = r_mem_ptr;
`else
    assign w_alu_ptr  = '0;
    assign w_mult_ptr = '0;
    assign w_mem_ptr  = '0;
`endif

    assign w_alu_pick  = f_pick(w_alu_req,  w_alu_ptr);
    assign w_mult_pick = f_pick(w_mult_req, w_mult_ptr);
    assign w_mem_pick  = f_pick(w_mem_req,  w_mem_ptr);

    assign alu_gnt  = !flush && w_alu_pick[c_IDX_W];
    assign mult_gnt = !flush && !mult_busy && w_mult_pick[c_IDX_W];
    assign mem_gnt  = !flush && mem_ready && w_mem_pick[c_IDX_W];

    assign alu_idx  = alu_gnt  ? w_alu_pick[c_IDX_W-1:0]  : '0;
    assign mult_idx = mult_gnt ? w_mult_pick[c_IDX_W-1:0] : '0;
    assign mem_idx  = mem_gnt  ? w_mem_pick[c_IDX_W-1:0]  : '0;

    // Completion fires off the 1->0 step; a flush in that same cycle cancels it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mult_cnt      <= '0;
            r_mult_tag      <= '0;
            r_mult_done     <= 1'b0;
            r_mult_done_idx <= '0;
        end else begin
            if (flush)
                r_mult_cnt <= '0;
            else if (mult_gnt)
                r_mult_cnt <= c_CNT_W'(MULT_LAT);
            else if (r_mult_cnt != '0)
                r_mult_cnt <= r_mult_cnt - 1'b1;

            if (mult_gnt)
                r_mult_tag <= mult_idx;

            r_mult_done <= !flush && (r_mult_cnt == c_CNT_W'(1));
            if (!flush && (r_mult_cnt == c_CNT_W'(1)))
                r_mult_done_idx <= r_mult_tag;
        end
    end

    assign mult_busy     = (r_mult_cnt != '0);
    assign mult_done     = r_mult_done;
    assign mult_done_idx = r_mult_done_idx;

endmodule
`default_nettype wire

// File: tb/tb_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_sched
// Brief    : Directed and randomized checks of issue_sched against a
//            cycle-indexed reference model (honours ISSUE_SCHED_RR_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_issue_sched;

    localparam int RS_SZ    = 5;
    localparam int MULT_LAT = 4;
    localparam int IW       = $clog2(RS_SZ);

    logic                  clock     = 1'b0;
    logic                  reset_n   = 1'b1;
    logic [RS_SZ-1:0]      req_valid = '0;
    logic [RS_SZ-1:0][1:0] req_fu    = '0;
    logic                  mem_ready = 1'b0;
    logic                  flush     = 1'b0;
    logic                  alu_gnt, mult_gnt, mem_gnt, mult_busy, mult_done;
    logic [IW-1:0]         alu_idx, mult_idx, mem_idx, mult_done_idx;

    issue_sched #(.RS_SZ(RS_SZ), .MULT_LAT(MULT_LAT)) u_dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_fu        (req_fu),
        .mem_ready     (mem_ready),
        .flush         (flush),
        .alu_gnt       (alu_gnt),
        .mult_gnt      (mult_gnt),
        .mem_gnt       (mem_gnt),
        .alu_idx       (alu_idx),
        .mult_idx      (mult_idx),
        .mem_idx       (mem_idx),
        .mult_busy     (mult_busy),
        .mult_done     (mult_done),
        .mult_done_idx (mult_done_idx)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: multiply tracked by grant cycle, pointers as plain ints.
    int cyc, g_cyc, lat_idx, last_done_idx, p_alu, p_mult, p_mem;
    bit active;
    int obs_alu_gnt, obs_alu_idx, obs_mult_gnt, obs_mult_idx, obs_mem_gnt, obs_mem_idx;
    int obs_busy, obs_done, obs_done_idx;

    task automatic model_reset();
        cyc = 0; g_cyc = -100; lat_idx = 0; last_done_idx = 0;
        p_alu = 0; p_mult = 0; p_mem = 0; active = 1'b0;
    endtask

    function automatic int pick(input logic [RS_SZ-1:0] v, input logic [RS_SZ-1:0][1:0] fu,
                                input int lo, input int hi, input int ptr);
        for (int off = 0; off < RS_SZ; off++) begin
            int e;
            e = (ptr + off) % RS_SZ;
            if (v[IW'(e)] && int'(fu[IW'(e)]) >= lo && int'(fu[IW'(e)]) <= hi)
                return e;
        end
        return -1;
    endfunction

    task automatic step(input logic [RS_SZ-1:0] v, input logic [RS_SZ-1:0][1:0] fu,
                        input logic mr, input logic fl);
        int ea, em, eb;
        bit busy_e, done_e;
        req_valid = v; req_fu = fu; mem_ready = mr; flush = fl;
        @(negedge clock);
        busy_e = active && (cyc > g_cyc) && (cyc <= g_cyc + MULT_LAT);
        done_e = active && (cyc == g_cyc + MULT_LAT + 1);
        if (done_e) last_done_idx = lat_idx;
        ea = fl ? -1 : pick(v, fu, 0, 0, p_alu);
        em = (fl || busy_e) ? -1 : pick(v, fu, 1, 1, p_mult);
        eb = (fl || !mr) ? -1 : pick(v, fu, 2, 3, p_mem);
        obs_alu_gnt = int'(alu_gnt);   obs_alu_idx  = int'(alu_idx);
        obs_mult_gnt = int'(mult_gnt); obs_mult_idx = int'(mult_idx);
        obs_mem_gnt = int'(mem_gnt);   obs_mem_idx  = int'(mem_idx);
        obs_busy = int'(mult_busy);    obs_done     = int'(mult_done);
        obs_done_idx = int'(mult_done_idx);
        chk($sformatf("alu_gnt@%0d", cyc),  obs_alu_gnt,  int'(ea >= 0));
        chk($sformatf("alu_idx@%0d", cyc),  obs_alu_idx,  (ea >= 0) ? ea : 0);
        chk($sformatf("mult_gnt@%0d", cyc), obs_mult_gnt, int'(em >= 0));
        chk($sformatf("mult_idx@%0d", cyc), obs_mult_idx, (em >= 0) ? em : 0);
        chk($sformatf("mem_gnt@%0d", cyc),  obs_mem_gnt,  int'(eb >= 0));
        chk($sformatf("mem_idx@%0d", cyc),  obs_mem_idx,  (eb >= 0) ? eb : 0);
        chk($sformatf("mult_busy@%0d", cyc), obs_busy, int'(busy_e));
        chk($sformatf("mult_done@%0d", cyc), obs_done, int'(done_e));
        chk($sformatf("done_idx@%0d", cyc),  obs_done_idx, last_done_idx);
        @(posedge clock);
        if (em >= 0) begin g_cyc = cyc; active = 1'b1; lat_idx = em; end
        if (fl) active = 1'b0;
`ifdef ISSUE_SCHED_RR_EN
        if (ea >= 0) p_alu  = (ea + 1) % RS_SZ;
        if (em >= 0) p_mult = (em + 1) % RS_SZ;
        if (eb >= 0) p_mem  = (eb + 1) % RS_SZ;
`endif
        cyc++;
        #1;
    endtask

    // Reset is asserted mid-cycle so its effect is visibly asynchronous.
    task automatic do_reset();
        req_valid = '0; req_fu = '0; mem_ready = 1'b0; flush = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        chk("rst_busy", int'(mult_busy), 0);
        chk("rst_done", int'(mult_done), 0);
        chk("rst_done_idx", int'(mult_done_idx), 0);
        chk("rst_gnts", int'({alu_gnt, mult_gnt, mem_gnt}), 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [RS_SZ-1:0][1:0] f;
        int seq [3];
        int exp_seq [3];

        model_reset();
        do_reset();
        step('0, '0, 1'b1, 1'b0);

        // Two ALU requests, lowest wins from pointer 0.
        do_reset();
        step(5'b00101, '0, 1'b0, 1'b0);
        chk("d029_alu_gnt", obs_alu_gnt, 1);
        chk("d029_alu_idx", obs_alu_idx, 0);
        chk("d029_others", obs_mult_gnt + obs_mem_gnt, 0);

        // Persistent ALU requests on entries 0 and 4.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(5'b10001, '0, 1'b1, 1'b0);
            seq[k] = obs_alu_idx;
        end
`ifdef ISSUE_SCHED_RR_EN
        exp_seq = '{0, 4, 0};
`else
        exp_seq = '{0, 0, 0};
`endif
        for (int k = 0; k < 3; k++)
            chk($sformatf("d032_seq%0d", k), seq[k], exp_seq[k]);

        // LOAD on 1, STORE on 2, memory first stalled then ready.
        do_reset();
        f = '0; f[1] = 2'd2; f[2] = 2'd3;
        step(5'b00110, f, 1'b0, 1'b0);
        chk("d031_stall", obs_mem_gnt, 0);
        step(5'b00110, f, 1'b1, 1'b0);
        chk("d031_gnt", obs_mem_gnt, 1);
        chk("d031_idx", obs_mem_idx, 1);

        // Entry 3 multiply, then entry 1 waits and issues on the done cycle.
        do_reset();
        f = '0; f[3] = 2'd1;
        step(5'b01000, f, 1'b0, 1'b0);
        chk("d030_gnt0", obs_mult_gnt, 1);
        chk("d030_idx0", obs_mult_idx, 3);
        f = '0; f[1] = 2'd1;
        for (int k = 1; k <= 5; k++) begin
            step(5'b00010, f, 1'b0, 1'b0);
            chk($sformatf("d030_busy%0d", k), obs_busy, int'(k <= 4));
            chk($sformatf("d030_done%0d", k), obs_done, int'(k == 5));
            chk($sformatf("d030_mgnt%0d", k), obs_mult_gnt, int'(k == 5));
        end
        chk("d030_done_idx", obs_done_idx, 3);
        chk("d030_idx5", obs_mult_idx, 1);

        // Flush in cycle 2 of a multiply, with every FU class requesting.
        do_reset();
        f = '0; f[2] = 2'd1;
        step(5'b00100, f, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        f = '0; f[1] = 2'd1; f[2] = 2'd2; f[3] = 2'd3;
        step(5'b11111, f, 1'b1, 1'b1);
        chk("d033_gnts", obs_alu_gnt + obs_mult_gnt + obs_mem_gnt, 0);
        for (int k = 3; k < 9; k++) begin
            step('0, '0, 1'b0, 1'b0);
            if (k == 3) chk("d033_busy", obs_busy, 0);
            chk($sformatf("d033_nodone%0d", k), obs_done, 0);
        end

        // Asynchronous reset while a multiply is in flight.
        do_reset();
        f = '0; f[4] = 2'd1;
        step(5'b10000, f, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        chk("d034_busy_pre", obs_busy, 1);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step('0, '0, 1'b0, 1'b0);
            chk($sformatf("d034_nodone%0d", k), obs_done, 0);
        end

        // Randomized traffic with occasional flushes and resets.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            step(RS_SZ'($urandom), (2*RS_SZ)'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 11) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/issue_sched.md
ISSUE_SCHED -- requirements
Module: issue_sched

Interface
REQ-001 SHALL have parameter RS_SZ, default 5, number of reservation-station entries arbitrated.
REQ-002 SHALL have parameter MULT_LAT, default 4, multiplier occupancy in cycles (legal range 1..15).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  RS_SZ  entry i is busy, not yet issued, and operands ready.
REQ-006 SHALL have port req_fu  input  RS_SZ x 2  FU class per entry: 0 ALU, 1 MULT, 2 LOAD, 3 STORE.
REQ-007 SHALL have port mem_ready  input  1  memory port can accept a LOAD/STORE this cycle.
REQ-008 SHALL have port flush  input  1  squash: cancel the in-flight multiply and suppress all grants this cycle.
REQ-009 SHALL have ports alu_gnt, mult_gnt, mem_gnt  output  1 each  grant valid per FU.
REQ-010 SHALL have ports alu_idx, mult_idx, mem_idx  output  clog2(RS_SZ) each  granted entry index.
REQ-011 SHALL have port mult_busy  output  1  multiplier occupied.
REQ-012 SHALL have ports mult_done, mult_done_idx  output  1 / clog2(RS_SZ)  one-cycle pulse and entry index at multiply completion.

Function
REQ-013 Grants SHALL be combinational from the current-cycle requests and registered state; zero-cycle request-to-grant latency.
REQ-014 ALU SHALL grant at most one entry per cycle among req_valid entries with req_fu==0; it never stalls.
REQ-015 MULT SHALL grant at most one entry with req_fu==1, and only when mult_busy==0.
REQ-016 MEM SHALL grant at most one entry with req_fu==2 or 3, and only when mem_ready==1; loads and stores share a single arbiter.
REQ-017 No entry SHALL be granted by more than one FU in the same cycle; each idx output SHALL be 0 when its gnt is 0.
REQ-018 When flush==1, all gnt outputs SHALL be 0, the multiplier counter SHALL clear to 0, and no mult_done SHALL pulse for the cancelled op.
REQ-019 On a mult grant (posedge with mult_gnt==1), the counter SHALL load MULT_LAT and the latch SHALL capture mult_idx; mult_busy SHALL be (counter!=0).
REQ-020 The counter SHALL decrement by 1 per cycle while non-zero; on the 1->0 transition, mult_done SHALL be 1 for exactly the following cycle, with mult_done_idx equal to the latched index.
REQ-021 A new mult grant SHALL be possible in the cycle mult_done is high, i.e. back-to-back multiplies at a spacing of MULT_LAT+1 cycles.
REQ-022 mult_done_idx SHALL hold its last value when mult_done==0.
REQ-023 Each arbiter SHALL keep its own priority pointer, clog2(RS_SZ) bits wide, that wraps from RS_SZ-1 to 0; pointer arithmetic is modulo RS_SZ.

Reset
REQ-024 Asserting reset_n low SHALL immediately clear the counter, all pointers, and mult_done_idx to 0; mult_busy and mult_done SHALL go to 0 without waiting for a clock.
REQ-025 Reset asserted while a multiply is in flight SHALL abandon it with no mult_done pulse.
REQ-026 The first arbitration after reset_n deasserts SHALL treat entry 0 as highest priority.

Configuration
REQ-027 With ISSUE_SCHED_RR_EN defined, each arbiter SHALL be round-robin: search starts at its pointer, and after a grant of index k the pointer SHALL become (k+1) mod RS_SZ; with no grant, the pointer SHALL hold.
REQ-028 Without ISSUE_SCHED_RR_EN, each arbiter SHALL use fixed priority with the lowest index winning, and the pointers SHALL not exist or SHALL stay constant at 0.

Verification
REQ-029 Bench SHALL cover: req_valid=5'b00101, all req_fu=0 -> alu_gnt=1, alu_idx=0; mult_gnt=0, mem_gnt=0.
REQ-030 Bench SHALL cover: entry 3 MULT granted at cycle 0, MULT_LAT=4 -> mult_busy cycles 1-4, mult_done=1 with idx 3 at cycle 5, and a second MULT request granted at cycle 5.
REQ-031 Bench SHALL cover: LOAD on entry 1, STORE on entry 2, mem_ready=0 -> mem_gnt=0; then mem_ready=1 -> mem_gnt=1, idx=1 (pointer 0).
REQ-032 Bench SHALL cover, with ISSUE_SCHED_RR_EN: entries 0 and 4 hold ALU requests for 3 cycles -> alu_idx sequence 0, 4, 0; without the macro -> 0, 0, 0.
REQ-033 Bench SHALL cover: flush at cycle 2 of a multiply -> mult_busy=0 next cycle, no mult_done, and all gnt outputs 0 during the flush cycle.
REQ-034 Bench SHALL cover: reset_n pulsed low mid-clock during a multiply -> mult_busy drops asynchronously, with no mult_done afterwards.
